axis_stream_receiver: RTL
=========================

# axis_stream_receiver

AXI-Stream slave that terminates the stream produced by the team's AXI-Stream master. It accepts beats under tvalid/tready handshake and buffers them in a first-word-fall-through FIFO for a local consumer. Null beats are dropped, and per-packet byte and packet counts are kept for the testbench and for status readback.

## Interface
Parameters:
- N, 4, bytes per beat; tdata is 8*N bits.
- DEPTH, 8, FIFO depth in beats; power of two, ≥2.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- tvalid  in  1  master beat valid.
- tready  out  1  receiver can accept a beat.
- tdata  in  8*N  beat data.
- tstrb  in  N  byte qualifier: 1 = data/position byte.
- tkeep  in  N  byte qualifier: 0 with tstrb 0 = null byte.
- tlast  in  1  last beat of packet.
- tid, tdest, tuser  in  1 each  ignored.
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  consumer pops the head.
- rd_data  out  8*N  head data.
- rd_strb  out  N  head tstrb.
- rd_keep  out  N  head tkeep.
- rd_last  out  1  head tlast.
- fifo_count  out  $clog2(DEPTH)+1  beats stored.
- pkt_count  out  16  packets received, modulo 2^16.
- last_pkt_bytes  out  16  data-byte count of the last completed packet.
- pkt_done  out  1  one-cycle pulse on packet completion.

## Operation
- Accept: a beat is accepted on a rising edge with tvalid && tready.
- tready = aresetn && (fifo_count != DEPTH). It depends only on registered state, with no combinational path from rd_ready or tvalid.
- Null beat: tstrb==0 && tkeep==0.
  - Accepted null beat with tlast=0: handshaken, not written to the FIFO, no counter effect.
  - Accepted null beat with tlast=1: written, so the packet boundary reaches the consumer.
- Non-null beats are written as {tdata, tstrb, tkeep, tlast}.
- FIFO is first-word-fall-through: rd_valid = (fifo_count != 0) and rd_* show mem[rd_ptr]. A pop occurs on rd_valid && rd_ready.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- fifo_count changes per edge: +1 on write only, -1 on pop only, unchanged on write and pop together.
- Byte accumulator acc (16-bit, internal): adds popcount(tstrb & tkeep) on every accepted beat and wraps modulo 2^16.
- Accepted beat with tlast=1, same edge:
  - last_pkt_bytes <= acc + popcount(tstrb & tkeep).
  - acc <= 0.
  - pkt_count <= pkt_count + 1.
  - pkt_done high in the next cycle only.
- tid, tdest and tuser are not stored.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge): pointers, fifo_count, acc, pkt_count, last_pkt_bytes and pkt_done all 0. rd_valid=0, rd_* contents are don't-care, tready=0 while aresetn is low.
- First edge after release: tready=1.
- Latency: a beat accepted at edge k appears on rd_* with rd_valid=1 after edge k. A minimum-latency pass-through takes one cycle.
- Throughput: one beat per cycle sustained when the consumer holds rd_ready=1.
- Full (fifo_count==DEPTH): tready=0 in the same cycle. A pop at that edge raises tready in the following cycle; there is no same-cycle pass-through of tready.
- Empty: rd_ready with rd_valid=0 is ignored, and the count never underflows.
- Write and pop at fifo_count==1: count stays 1 and the head advances to the new beat.
- The master may hold tvalid with tready low. The beat is sampled only on the handshake edge, and its stability is not checked.
- Reset mid-packet: FIFO contents, the partial acc and all counters are discarded. A beat presented on the reset-release edge is not accepted.

## Test plan
- Single packet, N=4: 3 beats (tstrb=tkeep=4'hF, tlast on beat 3), rd_ready=1.
  - Required: rd_* reproduce the beats 1 cycle later, pkt_count=1, last_pkt_bytes=12, pkt_done pulses once.
- Null and position beats: sequence {keep=F,strb=F}, {0,0}, {keep=0,strb=F}, {0,0,tlast=1}.
  - Required: 3 beats reach the FIFO (the middle null is dropped, the tlast null is kept).
  - Required: last_pkt_bytes=4, pkt_count=1.
- Backpressure: rd_ready=0, push DEPTH+2 beats continuously.
  - Required: tready falls after DEPTH accepts, fifo_count=DEPTH, and no beat is lost or duplicated.
  - Then rd_ready=1: all beats drain in order and tready returns 1 cycle after the first pop.
- Wrap-around: 3*DEPTH beats with a random rd_ready pattern.
  - Required: data order is preserved across pointer wrap and fifo_count never exceeds DEPTH.
- Simultaneous push and pop at count 1 and at full.
  - Required: count is unchanged and the head updates correctly.
- Reset mid-packet: assert aresetn low after 2 of 4 beats, then send a new 2-beat packet.
  - Required: all outputs reset, tready=0 during reset.
  - Required: the new packet gives pkt_count=1 and last_pkt_bytes=8.

Source files
------------

// File: rtl/axis_stream_receiver_if.sv
// axis_stream_receiver_if
// AXI-Stream channel bundle between a stream master and the receiver.
// Signals:
//   tvalid/tready  beat handshake (tready driven by the slave)
//   tdata          8*N bits of beat data
//   tstrb/tkeep    per-byte qualifiers (both 0 marks a null byte)
//   tlast          last beat of a packet
//   tid/tdest/tuser  sideband, carried but not used by the receiver
interface axis_stream_receiver_if #(
    parameter int N = 4
);
    logic           tvalid;
    logic           tready;
    logic [8*N-1:0] tdata;
    logic [N-1:0]   tstrb;
    logic [N-1:0]   tkeep;
    logic           tlast;
    logic           tid;
    logic           tdest;
    logic           tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_stream_receiver.sv
// axis_stream_receiver
// AXI-Stream slave that buffers accepted beats in a first-word-fall-through
// FIFO for a local consumer. Null beats without tlast are dropped; per-packet
// byte counts and a packet counter are kept for status readback.
// Ports:
//   aclk, aresetn     clock (rising edge), asynchronous active-low reset
//   s_axis            AXI-Stream slave side (tvalid/tready/tdata/tstrb/tkeep/tlast)
//   rd_valid/rd_ready FIFO head valid / consumer pop
//   rd_data/strb/keep/last  FIFO head contents
//   fifo_count        beats stored
//   pkt_count         packets received, modulo 2^16
//   last_pkt_bytes    data-byte count of the last completed packet
//   pkt_done          one-cycle pulse after a packet completes
module axis_stream_receiver #(
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axis_stream_receiver_if.slave    s_axis,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [8*N-1:0]           rd_data,
    output logic [N-1:0]             rd_strb,
    output logic [N-1:0]             rd_keep,
    output logic                     rd_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              pkt_count,
    output logic [15:0]              last_pkt_bytes,
    output logic                     pkt_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 8*N + 2*N + 1;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   pkt_count_q, pkt_count_d;
    logic [15:0]   last_bytes_q, last_bytes_d;
    logic          pkt_done_q, pkt_done_d;
    logic          running_q, running_d;

    logic          tready_int;
    logic          accept;
    logic          is_null;
    logic          wr_en;
    logic          pop;
    logic [15:0]   beat_bytes;

    function automatic logic [15:0] byte_count(input logic [N-1:0] bits);
        logic [15:0] total;
        total = '0;
        for (int i = 0; i < N; i++) begin
            total = total + 16'(bits[i]);
        end
        return total;
    endfunction

    // running_q holds tready low through the reset-release edge so a beat
    // presented on that edge is never accepted.
    assign tready_int    = aresetn && running_q && (count_q != (AW+1)'(DEPTH));
    assign s_axis.tready = tready_int;

    assign accept     = s_axis.tvalid && tready_int;
    assign is_null    = (s_axis.tstrb == '0) && (s_axis.tkeep == '0);
    // Null beats are only stored when they carry the packet boundary.
    assign wr_en      = accept && (!is_null || s_axis.tlast);
    assign pop        = rd_valid && rd_ready;
    assign beat_bytes = byte_count(s_axis.tstrb & s_axis.tkeep);

    assign rd_valid = (count_q != '0);
    assign {rd_data, rd_strb, rd_keep, rd_last} = mem[rd_ptr_q];

    assign fifo_count     = count_q;
    assign pkt_count      = pkt_count_q;
    assign last_pkt_bytes = last_bytes_q;
    assign pkt_done       = pkt_done_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        acc_d        = acc_q;
        pkt_count_d  = pkt_count_q;
        last_bytes_d = last_bytes_q;
        pkt_done_d   = 1'b0;
        running_d    = 1'b1;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (accept) begin
            if (s_axis.tlast) begin
                last_bytes_d = acc_q + beat_bytes;
                acc_d        = '0;
                pkt_count_d  = pkt_count_q + 16'd1;
                pkt_done_d   = 1'b1;
            end else begin
                acc_d = acc_q + beat_bytes;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            acc_q        <= '0;
            pkt_count_q  <= '0;
            last_bytes_q <= '0;
            pkt_done_q   <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            pkt_count_q  <= pkt_count_d;
            last_bytes_q <= last_bytes_d;
            pkt_done_q   <= pkt_done_d;
            running_q    <= running_d;
        end
    end

    // Storage needs no reset; stale entries are never visible while count is 0.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast};
        end
    end
endmodule
